shift_scheduler: RTL and testbench

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

---
 rtl/shift_sched_pkg.sv | 24 ++
 rtl/barrel_shifter.sv | 37 +++
 rtl/shift_scheduler.sv | 116 +++++++++++
 tb/tb_shift_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sched_pkg.sv
// Purpose: shared types and encodings for the two-requester shift scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_sched_pkg;

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Requester indices, as carried on out_id.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Shift direction encoding.
  localparam logic LR_RIGHT = 1'b0;
  localparam logic LR_LEFT  = 1'b1;

  // Fill mode encoding.
  localparam logic AL_LOGICAL = 1'b0;
  localparam logic AL_ARITH   = 1'b1;

endpackage

// File: rtl/barrel_shifter.sv
// Purpose: 8-bit combinational barrel shifter, left/right, logical/arithmetic.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: din (operand), shamt (0..7), lr (1=left), al (1=sign fill on right), dout.
module barrel_shifter
  import shift_sched_pkg::*;
(
  input  logic [7:0] din,
  input  logic [2:0] shamt,
  input  logic       lr,
  input  logic       al,
  output logic [7:0] dout
);

  logic       fill;
  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] s4;

  // Three log2 stages (1, 2, 4). The fill bit is taken from the original
  // operand; an arithmetic right shift keeps bit 7 equal to it at every stage.
  always_comb begin
    fill = ((al == AL_ARITH) && (lr == LR_RIGHT)) ? din[7] : 1'b0;

    s1 = din;
    if (shamt[0]) s1 = (lr == LR_LEFT) ? {din[6:0], 1'b0} : {fill, din[7:1]};

    s2 = s1;
    if (shamt[1]) s2 = (lr == LR_LEFT) ? {s1[5:0], 2'b00} : {{2{fill}}, s1[7:2]};

    s4 = s2;
    if (shamt[2]) s4 = (lr == LR_LEFT) ? {s2[3:0], 4'h0} : {{4{fill}}, s2[7:4]};

    dout = s4;
  end

endmodule

// File: rtl/shift_scheduler.sv
// Purpose: round-robin arbiter sharing one barrel shifter between two requesters,
//          result held in a single output register with valid/ready handshake.
// Latency: 1 cycle from acceptance to out_valid; one result per cycle sustained.
// Backpressure: while a result is held and out_ready=0, both reqN_ready are 0.
// Ports: clk, rst (async, active-high); reqN_{valid,ready,din,shamt,lr,al} for N=0,1;
//        out_{valid,ready,data,id}.
module shift_scheduler
  import shift_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_din,
  input  logic [2:0] req0_shamt,
  input  logic       req0_lr,
  input  logic       req0_al,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_din,
  input  logic [2:0] req1_shamt,
  input  logic       req1_lr,
  input  logic       req1_al,

  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_id
);

  state_t     state;
  logic       last_id;     // requester served most recently
  logic       can_accept;
  logic       grant;
  logic       accept;

  logic [7:0] sel_din;
  logic [2:0] sel_shamt;
  logic       sel_lr;
  logic       sel_al;
  logic [7:0] shifted;

  // Handshake: depends only on state, out_ready, valids and last_id.
  always_comb begin
    can_accept = (state == EMPTY) || out_ready;

    if (req0_valid && req1_valid) grant = ~last_id;
    else if (req1_valid)          grant = REQ1;
    else                          grant = REQ0;

    req0_ready = can_accept && req0_valid && (grant == REQ0);
    req1_ready = can_accept && req1_valid && (grant == REQ1);
    accept     = req0_ready || req1_ready;
  end

  // Command mux feeding the shared shifter.
  always_comb begin
    if (grant == REQ1) begin
      sel_din   = req1_din;
      sel_shamt = req1_shamt;
      sel_lr    = req1_lr;
      sel_al    = req1_al;
    end else begin
      sel_din   = req0_din;
      sel_shamt = req0_shamt;
      sel_lr    = req0_lr;
      sel_al    = req0_al;
    end
  end

  barrel_shifter u_shift (
    .din   (sel_din),
    .shamt (sel_shamt),
    .lr    (sel_lr),
    .al    (sel_al),
    .dout  (shifted)
  );

  // last_id resets to REQ1 so that req0 wins the first contended grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= 8'h00;
      out_id   <= REQ0;
      last_id  <= REQ1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state    <= FULL;
            out_data <= shifted;
            out_id   <= grant;
            last_id  <= grant;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (accept) begin
              out_data <= shifted;
              out_id   <= grant;
              last_id  <= grant;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_shift_scheduler.sv
// Purpose: self-checking bench for shift_scheduler: directed vectors with
//          literal expectations plus a per-cycle comparison against a
//          behavioural model (arithmetic shift, round-robin queue of turns).
module tb_shift_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 0, req1_valid = 0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_din = 0, req1_din = 0;
  logic [2:0] req0_shamt = 0, req1_shamt = 0;
  logic       req0_lr = 0, req1_lr = 0, req0_al = 0, req1_al = 0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din),
    .req0_shamt(req0_shamt), .req0_lr(req0_lr), .req0_al(req0_al),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din),
    .req1_shamt(req1_shamt), .req1_lr(req1_lr), .req1_al(req1_al),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_full = 0;
  bit [7:0] m_data = 0;
  bit       m_id   = 0;
  bit       m_last = 1;   // so requester 0 has the first turn

  // Shift as integer arithmetic: multiply for left, floor-divide for right.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int sh,
                                           input logic lr, input logic al);
    int v;
    if (lr) begin
      v = (int'(d) * (1 << sh)) % 256;
    end else begin
      v = int'(d);
      if (al && d[7]) v = v - 256;
      v = v >>> sh;
      v = v & 255;
    end
    return v[7:0];
  endfunction

  function automatic bit exp_rdy(input int n);
    bit want0, want1, mine;
    want0 = req0_valid;
    want1 = req1_valid;
    mine  = (n == 0) ? want0 : want1;
    if (m_full && !out_ready) return 1'b0;
    if (!mine) return 1'b0;
    if (want0 && want1) return (n != int'(m_last));
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full = 0; m_data = 0; m_id = 0; m_last = 1;
    end else begin
      bit r0, r1;
      r0 = exp_rdy(0);
      r1 = exp_rdy(1);
      if (r0) begin
        m_data = ref_shift(req0_din, int'(req0_shamt), req0_lr, req0_al);
        m_id = 0; m_last = 0; m_full = 1;
      end else if (r1) begin
        m_data = ref_shift(req1_din, int'(req1_shamt), req1_lr, req1_al);
        m_id = 1; m_last = 1; m_full = 1;
      end else if (out_ready) begin
        m_full = 0;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_ready0", int'(req0_ready), int'(exp_rdy(0)));
      chk("model_ready1", int'(req1_ready), int'(exp_rdy(1)));
      chk("model_valid", int'(out_valid), int'(m_full));
      if (m_full) begin
        chk("model_data", int'(out_data), int'(m_data));
        chk("model_id", int'(out_id), int'(m_id));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [7:0] d, input logic [2:0] s,
                      input logic lr, input logic al);
    req0_valid = v; req0_din = d; req0_shamt = s; req0_lr = lr; req0_al = al;
  endtask

  task automatic set1(input logic v, input logic [7:0] d, input logic [2:0] s,
                      input logic lr, input logic al);
    req1_valid = v; req1_din = d; req1_shamt = s; req1_lr = lr; req1_al = al;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] ids;
    do_reset();
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_data", int'(out_data), 8'h00);
    chk("reset_id", int'(out_id), 0);

    // Single left shift from req0.
    out_ready = 1;
    set0(1, 8'h81, 3'd1, 1, 0);
    step();
    set0(0, 0, 0, 0, 0);
    chk("l1_valid", int'(out_valid), 1);
    chk("l1_data", int'(out_data), 8'h02);
    chk("l1_id", int'(out_id), 0);

    // Arithmetic then logical right shift from req1.
    set1(1, 8'h80, 3'd3, 0, 1);
    step();
    chk("ar_data", int'(out_data), 8'hF0);
    chk("ar_id", int'(out_id), 1);
    set1(1, 8'h80, 3'd3, 0, 0);
    step();
    set1(0, 0, 0, 0, 0);
    chk("lr_data", int'(out_data), 8'h10);

    // shamt=0 passes the operand through for every lr/al combination.
    for (int k = 0; k < 4; k++) begin
      set0(1, 8'hA5, 3'd0, k[1], k[0]);
      step();
      chk("sh0_data", int'(out_data), 8'hA5);
    end
    set0(0, 0, 0, 0, 0);
    step();
    chk("drain_valid", int'(out_valid), 0);

    // Round-robin after reset: 0,1,0,1.
    do_reset();
    set0(1, 8'h11, 3'd1, 1, 0);
    set1(1, 8'h22, 3'd1, 0, 0);
    ids = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_valid", int'(out_valid), 1);
      ids[k] = out_id;
    end
    chk("rr_order", int'(ids[3:0]), 4'b1010);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step();

    // Stall for three cycles, then consume and reload on the same edge.
    out_ready = 0;
    set0(1, 8'h0F, 3'd2, 1, 0);
    step();
    set0(0, 0, 0, 0, 0);
    set1(1, 8'h40, 3'd1, 0, 0);
    chk("st_load", int'(out_data), 8'h3C);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_ready0", int'(req0_ready), 0);
      chk("st_ready1", int'(req1_ready), 0);
      step();
      chk("st_hold", int'(out_data), 8'h3C);
    end
    out_ready = 1;
    #1 chk("st_release_rdy", int'(req1_ready), 1);
    step();
    set1(0, 0, 0, 0, 0);
    chk("st_new_data", int'(out_data), 8'h20);
    chk("st_new_id", int'(out_id), 1);
    chk("st_new_valid", int'(out_valid), 1);
    step();

    // Asynchronous reset while a result is held.
    out_ready = 0;
    set0(1, 8'hFF, 3'd1, 1, 0);
    step();
    set0(0, 0, 0, 0, 0);
    chk("ar_held", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 8'h00);
    chk("arst_id", int'(out_id), 0);
    step();
    #2 rst = 1'b0;
    out_ready = 1;
    set0(1, 8'h01, 3'd7, 1, 1);
    set1(1, 8'h81, 3'd2, 0, 1);
    step();
    chk("post_rst_data0", int'(out_data), 8'h80);
    chk("post_rst_id0", int'(out_id), 0);
    set0(0, 0, 0, 0, 0);
    step();
    set1(0, 0, 0, 0, 0);
    chk("post_rst_data1", int'(out_data), 8'hE0);
    chk("post_rst_id1", int'(out_id), 1);

    // Mixed traffic with an irregular consumer; checked by the model each cycle.
    for (int k = 0; k < 40; k++) begin
      if (!(req0_valid && !req0_ready))
        set0(k % 3 != 2, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      if (!(req1_valid && !req1_ready))
        set1(k % 4 != 1, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      out_ready = (k % 5 != 3) && (k % 7 != 6);
      step();
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    out_ready = 1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
